// File: rtl/cordic_ctrl.sv
// Sequencing controller for an iterative CORDIC core: accepts one operand,
// steps the core through N micro-rotations plus two result loads, then holds the result.
module cordic_ctrl #(
  parameter  int B  = 14,
  parameter  int N  = 7,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic [8:1]    c,
  output logic [CW-1:0] cnt
);

  if (N < 2 || B < 1) begin : g_bad_params
    $fatal(1, "cordic_ctrl: N must be >= 2 and B >= 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ITER  = 3'd1,
    FIN_X = 3'd2,
    FIN_Y = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(N - 2);
  localparam logic [CW-1:0] CNT_MAX   = CW'(N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state and iteration counter; the counter stops at N-1 so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = CW'(0);
        if (in_valid) begin
          state_d = ITER;
        end else begin
          state_d = IDLE;
        end
      end
      ITER: begin
        if (cnt_q == LAST_ITER) begin
          state_d = FIN_X;
          cnt_d   = CNT_MAX;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      FIN_X: begin
        state_d = FIN_Y;
      end
      FIN_Y: begin
        state_d = DONE;
        cnt_d   = CW'(0);
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CW'(0);
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= CW'(0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode; the IDLE load strobes are gated by rst so reset forces c to zero.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    c         = 8'h00;
    cnt       = CW'(0);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        c[1]     = in_valid & rst;
        c[2]     = in_valid & rst;
        c[8]     = in_valid & rst;
      end
      ITER: begin
        cnt  = cnt_q;
        c[2] = 1'b1;
      end
      FIN_X: begin
        cnt  = CNT_MAX;
        c[6] = 1'b1;
      end
      FIN_Y: begin
        cnt  = CNT_MAX;
        c[5] = 1'b1;
        c[7] = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
